ped_crossing_ctrl: RTL and testbench

Pedestrian crossing controller that sits directly downstream of the intersection traffic-light FSM and consumes its one-hot `lights` vector. It debounces a raw pedestrian push-button, latches the request, and grants a WALK phase only at the start of a vehicle RED phase. The WALK phase is followed by a flashing DON'T-WALK clearance phase with a countdown. The block also detects illegal light codes and an early end of RED.

---
 rtl/ped_crossing_ctrl.sv | 155 +++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller: debounced request, WALK/FLASH phases on RED onset.
// Ports: clk, reset, lights, ped_btn -> walk, dont_walk, ped_wait, countdown, abort, fault.
module ped_crossing_ctrl #(
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned T_WALK     = 8,
  parameter int unsigned T_FLASH    = 6,
  parameter int unsigned BLINK_HALF = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] lights,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       ped_wait,
  output logic [7:0] countdown,
  output logic       abort,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    FLASH
  } state_t;

  state_t      state;
  logic        s1;
  logic        s;
  logic        deb;
  logic        deb_q;
  logic        red_q;
  logic [15:0] dcnt;
  logic [15:0] bcnt;
  logic [7:0]  cnt;

  logic legal;
  logic red_rise;
  logic deb_rise;
  logic grant;

  assign legal    = (lights == 3'b100) |
                    (lights == 3'b010) |
                    (lights == 3'b001);
  assign red_rise = lights[2] & ~red_q;
  assign deb_rise = deb & ~deb_q;
  assign grant    = (state == IDLE) & red_rise & ped_wait &
                    ~fault & legal;

  // Button synchronizer, debouncer and request latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1       <= 1'b0;
      s        <= 1'b0;
      deb      <= 1'b0;
      deb_q    <= 1'b0;
      dcnt     <= '0;
      ped_wait <= 1'b0;
      red_q    <= 1'b1;
    end else begin
      s1    <= ped_btn;
      s     <= s1;
      deb_q <= deb;
      red_q <= lights[2];
      if (s == deb) begin
        dcnt <= '0;
      end else if (dcnt == 16'(DEBOUNCE - 1)) begin
        deb  <= s;
        dcnt <= '0;
      end else begin
        dcnt <= dcnt + 16'd1;
      end
      // a press on the grant edge keeps the request for the next RED
      if (deb_rise) begin
        ped_wait <= 1'b1;
      end else if (grant) begin
        ped_wait <= 1'b0;
      end
    end
  end

  // Phase FSM with registered lamp outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bcnt      <= '0;
      walk      <= 1'b0;
      dont_walk <= 1'b1;
      countdown <= '0;
      abort     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (!legal) begin
        fault     <= 1'b1;
        state     <= IDLE;
        cnt       <= '0;
        bcnt      <= '0;
        walk      <= 1'b0;
        dont_walk <= 1'b1;
        countdown <= '0;
      end else if (state != IDLE && !lights[2]) begin
        abort     <= 1'b1;
        state     <= IDLE;
        cnt       <= '0;
        bcnt      <= '0;
        walk      <= 1'b0;
        dont_walk <= 1'b1;
        countdown <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (grant) begin
              state     <= WALK;
              cnt       <= 8'(T_WALK - 1);
              walk      <= 1'b1;
              dont_walk <= 1'b0;
            end
          end
          WALK: begin
            if (cnt == 8'd0) begin
              state     <= FLASH;
              cnt       <= 8'(T_FLASH - 1);
              bcnt      <= '0;
              walk      <= 1'b0;
              dont_walk <= 1'b1;
              countdown <= 8'(T_FLASH);
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          FLASH: begin
            if (cnt == 8'd0) begin
              state     <= IDLE;
              dont_walk <= 1'b1;
              countdown <= '0;
            end else begin
              cnt       <= cnt - 8'd1;
              countdown <= cnt;
              if (bcnt == 16'(BLINK_HALF - 1)) begin
                bcnt      <= '0;
                dont_walk <= ~dont_walk;
              end else begin
                bcnt <= bcnt + 16'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl.
// Drives lights/button sequences and checks lamp outputs against hand-derived values.
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] lights;
  logic       ped_btn;
  logic       walk;
  logic       dont_walk;
  logic       ped_wait;
  logic [7:0] countdown;
  logic       abort;
  logic       fault;

  int n_chk = 0;
  int n_err = 0;
  logic walk_seen;
  logic dw_low_seen;

  ped_crossing_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .lights    (lights),
    .ped_btn   (ped_btn),
    .walk      (walk),
    .dont_walk (dont_walk),
    .ped_wait  (ped_wait),
    .countdown (countdown),
    .abort     (abort),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    walk_seen   = walk_seen | walk;
    dw_low_seen = dw_low_seen | ~dont_walk;
  endtask

  task automatic run(input logic [2:0] l, input int n);
    lights = l;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int n);
    ped_btn = 1'b1;
    for (int i = 0; i < n; i++) tick();
    ped_btn = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_walk"}, 32'(walk), 0);
    check({tag, "_dw"}, 32'(dont_walk), 1);
    check({tag, "_cd"}, 32'(countdown), 0);
  endtask

  logic [7:0] exp_cd [6] = '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  logic       exp_dw [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset   = 1'b1;
    lights  = 3'b100;
    ped_btn = 1'b0;
    walk_seen   = 1'b0;
    dw_low_seen = 1'b0;
    #12;
    chk_idle("rst");
    check("rst_wait", 32'(ped_wait), 0);
    check("rst_abort", 32'(abort), 0);
    check("rst_fault", 32'(fault), 0);
    tick();
    reset = 1'b0;

    // short 3-cycle pulse must be ignored
    run(3'b001, 3);
    press(3);
    run(3'b001, 8);
    check("short_pulse", 32'(ped_wait), 0);

    // held press: ped_wait rises on edge 7
    ped_btn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("deb_e6", 32'(ped_wait), 0);
    tick();
    check("deb_e7", 32'(ped_wait), 1);
    ped_btn = 1'b0;

    // full WALK/FLASH phase
    run(3'b010, 2);
    lights = 3'b100;
    tick();
    check("e1_walk", 32'(walk), 1);
    check("e1_dw", 32'(dont_walk), 0);
    check("e1_wait", 32'(ped_wait), 0);
    check("e1_cd", 32'(countdown), 0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      check("walk_on", 32'(walk), 1);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      check("fl_walk", 32'(walk), 0);
      check("fl_cd", 32'(countdown), 32'(exp_cd[i]));
      check("fl_dw", 32'(dont_walk), 32'(exp_dw[i]));
    end
    tick();
    chk_idle("e15");
    run(3'b100, 1);

    // three upstream cycles with no request
    walk_seen   = 1'b0;
    dw_low_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      run(3'b001, 10);
      run(3'b010, 3);
      run(3'b100, 16);
    end
    check("noreq_walk", 32'(walk_seen), 0);
    check("noreq_dw", 32'(dw_low_seen), 0);

    // early RED end aborts WALK; press during WALK served next RED
    run(3'b001, 2);
    press(5);
    run(3'b001, 10);
    check("ab_wait", 32'(ped_wait), 1);
    run(3'b010, 2);
    lights = 3'b100;
    tick();
    check("ab_e1", 32'(walk), 1);
    ped_btn = 1'b1;
    for (int i = 2; i <= 5; i++) tick();
    check("ab_e5", 32'(walk), 1);
    lights = 3'b010;
    tick();
    check("ab_e6_abort", 32'(abort), 1);
    check("ab_e6_walk", 32'(walk), 0);
    check("ab_e6_dw", 32'(dont_walk), 1);
    tick();
    check("ab_e7_abort", 32'(abort), 0);
    tick();
    check("ab_e8_wait", 32'(ped_wait), 1);
    ped_btn = 1'b0;
    run(3'b001, 10);
    run(3'b010, 2);
    lights = 3'b100;
    tick();
    check("ab_next_walk", 32'(walk), 1);
    check("ab_next_wait", 32'(ped_wait), 0);
    run(3'b100, 15);
    chk_idle("ab_done");

    // async reset mid-WALK
    run(3'b001, 2);
    press(5);
    run(3'b001, 10);
    run(3'b010, 2);
    lights = 3'b100;
    tick();
    tick();
    tick();
    check("rw_walk", 32'(walk), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("rw_async");
    check("rw_wait", 32'(ped_wait), 0);
    #1;
    reset = 1'b0;
    walk_seen = 1'b0;
    run(3'b100, 3);
    run(3'b001, 5);
    run(3'b010, 2);
    run(3'b100, 16);
    check("rw_nowalk", 32'(walk_seen), 0);

    // illegal code sets sticky fault and blocks grants
    run(3'b110, 1);
    check("flt_set", 32'(fault), 1);
    chk_idle("flt");
    run(3'b001, 3);
    check("flt_sticky", 32'(fault), 1);
    press(5);
    run(3'b001, 10);
    check("flt_wait", 32'(ped_wait), 1);
    walk_seen = 1'b0;
    run(3'b010, 2);
    run(3'b100, 16);
    check("flt_nowalk", 32'(walk_seen), 0);
    check("flt_hold", 32'(fault), 1);
    check("flt_wait2", 32'(ped_wait), 1);
    #2;
    reset = 1'b1;
    #1;
    check("flt_clr", 32'(fault), 0);
    check("flt_clr_wait", 32'(ped_wait), 0);
    #1;
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
